// File: rtl/gameover_sequencer.sv
// gameover_sequencer
//   Sequences a game through idle, play, a frozen death hold and a blinking
//   game-over screen, then back to play on a (locked-out) button press.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for first start press; nothing runs
//   PLAY  | gameplay advances; a collision freezes the screen
//   DEATH | screen frozen for HOLD_FRAMES frames
//   OVER  | game-over text blinks; restart allowed after LOCK_FRAMES
//
// Ports
//   clk         system clock (shared with VGA sync / ROM logic)
//   reset       synchronous active-high reset
//   frame_tick  one-cycle pulse per video frame
//   collision   level, player overlaps a hazard
//   btn         debounced start/restart button level
//   game_en     registered, high in PLAY
//   gameover_en registered, game-over text gate (blink phase in OVER)
//   restart     registered one-cycle pulse clearing the game state
//   state       current state (IDLE=0, PLAY=1, DEATH=2, GAMEOVER=3)

module gameover_sequencer #(
  parameter int HOLD_FRAMES  = 60,
  parameter int BLINK_FRAMES = 30,
  parameter int LOCK_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       btn,
  output logic       game_en,
  output logic       gameover_en,
  output logic       restart,
  output logic [1:0] state
);

  localparam int MAX_HB = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
  localparam int MAX_P  = (MAX_HB > LOCK_FRAMES) ? MAX_HB : LOCK_FRAMES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX   = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_DEATH    = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_btn_q;
  logic [CNT_W-1:0] r_frame_cnt;  // death hold count, reused as blink count
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_blink_phase;
  logic             r_game_en;
  logic             r_gameover_en;
  logic             r_restart;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_frame_cnt_nxt;
  logic [CNT_W-1:0] w_lock_cnt_nxt;
  logic             w_blink_nxt;
  logic             w_restart_nxt;
  logic             w_btn_edge;

  assign w_btn_edge = btn & ~r_btn_q;

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_blink_nxt     = r_blink_phase;
    w_restart_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_edge) begin
          w_state_nxt   = S_PLAY;
          w_restart_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        // A tick in the same cycle as the collision is deliberately not counted.
        if (collision) begin
          w_state_nxt     = S_DEATH;
          w_frame_cnt_nxt = CNT_ZERO;
        end
      end
      S_DEATH: begin
        if (frame_tick) begin
          if (r_frame_cnt == HOLD_LAST) begin
            w_state_nxt     = S_GAMEOVER;
            w_frame_cnt_nxt = CNT_ZERO;
            w_lock_cnt_nxt  = CNT_ZERO;
            w_blink_nxt     = 1'b1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_ONE;
          end
        end
      end
      S_GAMEOVER: begin
        if (frame_tick) begin
          if (r_frame_cnt == BLINK_LAST) begin
            w_frame_cnt_nxt = CNT_ZERO;
            w_blink_nxt     = ~r_blink_phase;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_ONE;
          end
          if (r_lock_cnt != LOCK_MAX) begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
          end
        end
        // Lock is judged on the registered count, so a press on the tick
        // that completes the lock period is still ignored.
        if (w_btn_edge && (r_lock_cnt == LOCK_MAX)) begin
          w_state_nxt   = S_PLAY;
          w_restart_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_btn_q       <= btn;
      r_frame_cnt   <= CNT_ZERO;
      r_lock_cnt    <= CNT_ZERO;
      r_blink_phase <= 1'b0;
      r_game_en     <= 1'b0;
      r_gameover_en <= 1'b0;
      r_restart     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_btn_q       <= btn;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_blink_phase <= w_blink_nxt;
      r_game_en     <= (w_state_nxt == S_PLAY);
      r_gameover_en <= (w_state_nxt == S_GAMEOVER) && w_blink_nxt;
      r_restart     <= w_restart_nxt;
    end
  end

  assign game_en     = r_game_en;
  assign gameover_en = r_gameover_en;
  assign restart     = r_restart;
  assign state       = r_state;

endmodule

// File: tb/tb_gameover_sequencer.sv
// Testbench for gameover_sequencer: directed scenarios plus a randomized run
// against an event-level reference model (tick totals, division for blink).

module tb_gameover_sequencer;

  localparam int HOLD  = 60;
  localparam int BLINK = 30;
  localparam int LOCK  = 90;

  logic       clk = 1'b0;
  logic       reset, frame_tick, collision, btn;
  logic       game_en, gameover_en, restart;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int   m_state = 0;
  int   m_death_ticks = 0;
  int   m_go_ticks = 0;
  logic m_btn_prev = 1'b0;
  logic m_restart = 1'b0;

  gameover_sequencer #(
    .HOLD_FRAMES (HOLD),
    .BLINK_FRAMES(BLINK),
    .LOCK_FRAMES (LOCK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .collision  (collision),
    .btn        (btn),
    .game_en    (game_en),
    .gameover_en(gameover_en),
    .restart    (restart),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic exp_game_en();
    return (m_state == 1);
  endfunction

  function automatic logic exp_gameover_en();
    return (m_state == 3) && (((m_go_ticks / BLINK) % 2) == 0);
  endfunction

  task automatic model(input logic r, input logic t, input logic c, input logic b);
    logic edge_seen;
    edge_seen  = b & ~m_btn_prev;
    m_btn_prev = b;
    m_restart  = 1'b0;
    if (r) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (edge_seen) begin m_state = 1; m_restart = 1'b1; end
        1: if (c) begin m_state = 2; m_death_ticks = 0; end
        2: if (t) begin
             m_death_ticks++;
             if (m_death_ticks == HOLD) begin m_state = 3; m_go_ticks = 0; end
           end
        default: begin
          if (edge_seen && m_go_ticks >= LOCK) begin
            m_state = 1; m_restart = 1'b1;
          end else if (t) begin
            m_go_ticks++;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic t, input logic c, input logic b);
    reset = r; frame_tick = t; collision = c; btn = b;
    @(posedge clk);
    model(r, t, c, b);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", state); end
    n_cmp++; if (game_en !== 1'b0) begin n_err++; $display("FAIL reset_game_en got=%b want=0", game_en); end
    n_cmp++; if (gameover_en !== 1'b0) begin n_err++; $display("FAIL reset_gameover_en got=%b want=0", gameover_en); end
    n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL reset_restart got=%b want=0", restart); end
    step(0, 1, 1, 0);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_ignores_collision got=%0d want=0", state); end
  endtask

  task automatic test_start();
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b1) begin n_err++; $display("FAIL start_restart got=%b want=1", restart); end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL start_state got=%0d want=1", state); end
    n_cmp++; if (game_en !== 1'b1) begin n_err++; $display("FAIL start_game_en got=%b want=1", game_en); end
    step(0, 1, 0, 1);
    n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL start_restart_width got=%b want=0", restart); end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL play_holds got=%0d want=1", state); end
  endtask

  task automatic test_death_hold();
    step(0, 1, 1, 1);  // collision coincident with a tick: tick not counted
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL death_enter got=%0d want=2", state); end
    n_cmp++; if (game_en !== 1'b0) begin n_err++; $display("FAIL death_game_en got=%b want=0", game_en); end
    for (int k = 1; k <= HOLD; k++) begin
      step(0, 1, 0, 1);
      n_cmp++;
      if (state !== ((k < HOLD) ? 2'd2 : 2'd3)) begin
        n_err++; $display("FAIL death_tick%0d_state got=%0d want=%0d", k, state, (k < HOLD) ? 2 : 3);
      end
      step(0, 0, 1, 1);
    end
    n_cmp++; if (gameover_en !== 1'b1) begin n_err++; $display("FAIL gameover_first_phase got=%b want=1", gameover_en); end
  endtask

  task automatic test_lock_and_blink();
    logic want;
    step(0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL lock_early_restart got=%b want=0", restart); end
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL lock_early_state got=%0d want=3", state); end
    step(0, 0, 0, 0);
    for (int k = 11; k <= LOCK; k++) begin
      step(0, 1, 0, 0);
      want = ((k / BLINK) % 2) == 0;
      n_cmp++;
      if (gameover_en !== want) begin
        n_err++; $display("FAIL blink_tick%0d got=%b want=%b", k, gameover_en, want);
      end
      if (k == LOCK - 1) begin
        step(0, 0, 0, 1);
        n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL lock_boundary_restart got=%b want=0", restart); end
        step(0, 0, 0, 0);
      end
    end
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b1) begin n_err++; $display("FAIL lock_release_restart got=%b want=1", restart); end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL lock_release_state got=%0d want=1", state); end
    n_cmp++; if (gameover_en !== 1'b0) begin n_err++; $display("FAIL lock_release_gameover_en got=%b want=0", gameover_en); end
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL lock_release_width got=%b want=0", restart); end
  endtask

  task automatic test_btn_through_reset();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b0) begin n_err++; $display("FAIL held_btn_restart got=%b want=0", restart); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL held_btn_state got=%0d want=0", state); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b1) begin n_err++; $display("FAIL repress_restart got=%b want=1", restart); end
  endtask

  task automatic test_reset_mid_death();
    step(0, 0, 1, 1);
    for (int k = 0; k < 20; k++) begin step(0, 1, 0, 1); step(0, 0, 0, 0); end
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL mid_death_state got=%0d want=2", state); end
    step(1, 1, 0, 0);
    n_cmp++; if ({state, game_en, gameover_en, restart} !== 5'b0) begin
      n_err++; $display("FAIL mid_death_reset got=%b want=00000", {state, game_en, gameover_en, restart});
    end
    step(0, 0, 1, 0);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL post_reset_collision got=%0d want=0", state); end
    step(0, 0, 0, 1);
    n_cmp++; if (restart !== 1'b1) begin n_err++; $display("FAIL post_reset_start got=%b want=1", restart); end
  endtask

  task automatic test_random();
    logic r, t, c, b, prev_restart;
    b = 1'b0;
    prev_restart = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      r = ($urandom_range(0, 1499) == 0);
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) b = ~b;
      step(r, t, c, b);
      n_cmp++;
      if (state !== 2'(m_state)) begin n_err++; $display("FAIL rnd%0d_state got=%0d want=%0d", i, state, m_state); end
      n_cmp++;
      if (game_en !== exp_game_en()) begin n_err++; $display("FAIL rnd%0d_game_en got=%b want=%b", i, game_en, exp_game_en()); end
      n_cmp++;
      if (gameover_en !== exp_gameover_en()) begin
        n_err++; $display("FAIL rnd%0d_gameover_en got=%b want=%b", i, gameover_en, exp_gameover_en());
      end
      n_cmp++;
      if (restart !== m_restart) begin n_err++; $display("FAIL rnd%0d_restart got=%b want=%b", i, restart, m_restart); end
      n_cmp++;
      if ((prev_restart & restart) !== 1'b0) begin n_err++; $display("FAIL rnd%0d_restart_double got=1 want=0", i); end
      prev_restart = restart;
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; collision = 1'b0; btn = 1'b0;
    test_reset();
    test_start();
    test_death_hold();
    test_lock_and_blink();
    test_btn_through_reset();
    test_reset_mid_death();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
